// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display path.
// Segment buses are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000000;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [NUM_DIGITS-1:0][3:0] digit_vec_t;

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd7.sv
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Non-BCD codes light every segment so a bad digit is visible on the board.
module BCD7
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_ERR;
        unique case (bcd_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// data commit, leading-zero blanking and per-digit blinking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d0_i,
    input  logic [3:0] d1_i,
    input  logic [3:0] d2_i,
    input  logic [3:0] d3_i,
    input  logic       load_i,
    input  logic       blank_lz_i,
    input  logic [3:0] blink_mask_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       frame_done_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    digit_vec_t      stage_q, stage_d;
    digit_vec_t      disp_q, disp_d;
    logic            pend_q, pend_d;
    logic [FrmW-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic            frame_phase_q, frame_phase_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;

    logic       tick;
    logic       wrap;
    digit_vec_t d_in;
    logic [3:0] cur_digit;
    logic [6:0] dec_seg;
    logic       lz_zero;
    logic       blanked;

    always_comb begin
        tick  = (cnt_q == CntW'(CLK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        wrap  = tick && (idx_q == 2'd3);
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        d_in    = {d3_i, d2_i, d1_i, d0_i};
        stage_d = load_i ? d_in : stage_q;
        pend_d  = pend_q | load_i;
        disp_d  = disp_q;
        // A load landing on the wrap bypasses staging so it shows this frame.
        if (wrap) begin
            if (load_i) begin
                disp_d = d_in;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = stage_q;
                pend_d = 1'b0;
            end
        end

        fcnt_d        = fcnt_q;
        phase_d       = phase_q;
        frame_phase_d = frame_phase_q;
        // Each frame uses the phase as it stood when the frame began, so all
        // four digits of a frame agree on visibility.
        if (wrap) begin
            frame_phase_d = phase_q;
            if (fcnt_q == FrmW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        frame_done_d = wrap;
    end

    assign cur_digit = disp_d[idx_d];

    BCD7 u_bcd7 (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        lz_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_d) && disp_d[i] != 4'd0) begin
                lz_zero = 1'b0;
            end
        end
        blanked = (blank_lz_i && (idx_d != 2'd0) && lz_zero) ||
                  (blink_mask_i[idx_d] && !frame_phase_d);

        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            if (blanked) begin
                seg_d = SEG_BLANK;
                an_d  = AN_OFF;
            end else begin
                seg_d = dec_seg;
                an_d  = an_select(idx_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd3;
            stage_q       <= '0;
            disp_q        <= '0;
            pend_q        <= 1'b0;
            fcnt_q        <= '0;
            phase_q       <= 1'b1;
            frame_phase_q <= 1'b1;
            seg_q         <= SEG_BLANK;
            an_q          <= AN_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_q       <= stage_d;
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
            frame_phase_q <= frame_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=4, BLINK_FRAMES=2.
// Edge e counts rising edges after reset release; outputs are sampled 1ns after.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] blink_mask = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .CLK_DIV      (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d0_i         (d0),
        .d1_i         (d1),
        .d2_i         (d2),
        .d3_i         (d3),
        .load_i       (load),
        .blank_lz_i   (blank_lz),
        .blink_mask_i (blink_mask),
        .seg_o        (seg),
        .an_o         (an),
        .frame_done_o (frame_done)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int idx);
        case (idx)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int a3, input int a2, input int a1, input int a0);
        d3 = 4'(a3);
        d2 = 4'(a2);
        d1 = 4'(a1);
        d0 = 4'(a0);
    endtask

    // Leaves the bench just after "edge 0": the next rising edge is e1.
    task automatic do_reset();
        rst_n      = 1'b0;
        load       = 1'b0;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        set_digits(0, 0, 0, 0);
        wait_edges(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic       exp_fd;
        rst_n = 1'b0;
        wait_edges(2);
        n_checks++;
        if (seg !== 7'b1111111) $display("FAIL reset_seg: got %b want 1111111", seg);
        else n_pass++;
        n_checks++;
        if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an);
        else n_pass++;
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done);
        else n_pass++;
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            wait_edges(1);
            exp_an = (e >= 4) ? 4'b1110 : 4'b1111;
            exp_fd = (e == 4);
            n_checks++;
            if (an !== exp_an) $display("FAIL first_frame_an e%0d: got %b want %b", e, an, exp_an);
            else n_pass++;
            n_checks++;
            if (frame_done !== exp_fd)
                $display("FAIL first_frame_fd e%0d: got %b want %b", e, frame_done, exp_fd);
            else n_pass++;
            if (e >= 4) begin
                n_checks++;
                if (seg !== 7'b1000000) $display("FAIL first_frame_seg e%0d: got %b want 1000000", e, seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_scan_order();
        int idx;
        do_reset();
        set_digits(1, 2, 3, 4);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        set_digits(8, 8, 8, 8);
        wait_edges(2);
        for (int e = 4; e <= 19; e++) begin
            wait_edges(1);
            idx = (e - 4) / 4;
            n_checks++;
            if (an !== an_of(idx)) $display("FAIL scan_an e%0d: got %b want %b", e, an, an_of(idx));
            else n_pass++;
            n_checks++;
            if (seg !== seg_of(4 - idx)) $display("FAIL scan_seg e%0d: got %b want %b", e, seg, seg_of(4 - idx));
            else n_pass++;
        end
    endtask

    task automatic test_frame_sync();
        int idx;
        int v;
        do_reset();
        set_digits(1, 2, 3, 4);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        wait_edges(8);
        set_digits(5, 6, 7, 8);
        load = 1'b1;
        wait_edges(1);
        set_digits(9, 9, 9, 9);
        wait_edges(1);
        load = 1'b0;
        set_digits(0, 0, 0, 0);
        for (int e = 12; e <= 35; e++) begin
            wait_edges(1);
            idx = ((e - 4) / 4) % 4;
            v   = (e < 20) ? 4 - idx : 9;
            n_checks++;
            if (an !== an_of(idx)) $display("FAIL sync_an e%0d: got %b want %b", e, an, an_of(idx));
            else n_pass++;
            n_checks++;
            if (seg !== seg_of(v)) $display("FAIL sync_seg e%0d: got %b want %b", e, seg, seg_of(v));
            else n_pass++;
        end
    endtask

    task automatic test_lz_blank();
        int         idx;
        logic       blank;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        do_reset();
        blank_lz = 1'b1;
        set_digits(0, 0, 7, 0);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        wait_edges(2);
        for (int e = 4; e <= 35; e++) begin
            if (e == 20) blank_lz = 1'b0;
            wait_edges(1);
            idx     = ((e - 4) / 4) % 4;
            blank   = (e < 20) && (idx >= 2);
            exp_seg = blank ? 7'b1111111 : seg_of((idx == 1) ? 7 : 0);
            exp_an  = blank ? 4'b1111 : an_of(idx);
            n_checks++;
            if (an !== exp_an) $display("FAIL lz_an e%0d: got %b want %b", e, an, exp_an);
            else n_pass++;
            n_checks++;
            if (seg !== exp_seg) $display("FAIL lz_seg e%0d: got %b want %b", e, seg, exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        int         idx;
        int         k;
        logic       vis;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        do_reset();
        blink_mask = 4'b0001;
        set_digits(0, 0, 0, 12);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        wait_edges(2);
        for (int e = 4; e <= 99; e++) begin
            wait_edges(1);
            idx     = ((e - 4) / 4) % 4;
            k       = (e - 4) / 16 + 1;
            vis     = (idx != 0) || (((k - 1) / 2) % 2 == 0);
            exp_seg = !vis ? 7'b1111111 : (idx == 0) ? 7'b0000000 : seg_of(0);
            exp_an  = vis ? an_of(idx) : 4'b1111;
            n_checks++;
            if (an !== exp_an) $display("FAIL blink_an e%0d: got %b want %b", e, an, exp_an);
            else n_pass++;
            n_checks++;
            if (seg !== exp_seg) $display("FAIL blink_seg e%0d: got %b want %b", e, seg, exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_and_load_wrap();
        int idx;
        int vals[4];
        vals[0] = 3;
        vals[1] = 7;
        vals[2] = 6;
        vals[3] = 5;
        do_reset();
        set_digits(1, 2, 3, 4);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        wait_edges(12);
        n_checks++;
        if (an !== 4'b1011) $display("FAIL mid_pre_an: got %b want 1011", an);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 4'b1111) $display("FAIL mid_rst_an: got %b want 1111", an);
        else n_pass++;
        n_checks++;
        if (seg !== 7'b1111111) $display("FAIL mid_rst_seg: got %b want 1111111", seg);
        else n_pass++;
        wait_edges(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            wait_edges(1);
            n_checks++;
            if (an !== 4'b1111 || frame_done !== 1'b0)
                $display("FAIL mid_restart e%0d: got an=%b fd=%b want an=1111 fd=0", e, an, frame_done);
            else n_pass++;
        end
        set_digits(5, 6, 7, 3);
        load = 1'b1;
        wait_edges(1);
        load = 1'b0;
        set_digits(0, 0, 0, 0);
        n_checks++;
        if (frame_done !== 1'b1) $display("FAIL wrap_load_fd: got %b want 1", frame_done);
        else n_pass++;
        for (int e = 4; e <= 23; e++) begin
            if (e > 4) wait_edges(1);
            idx = ((e - 4) / 4) % 4;
            n_checks++;
            if (an !== an_of(idx)) $display("FAIL wrap_load_an e%0d: got %b want %b", e, an, an_of(idx));
            else n_pass++;
            n_checks++;
            if (seg !== seg_of(vals[idx]))
                $display("FAIL wrap_load_seg e%0d: got %b want %b", e, seg, seg_of(vals[idx]));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_frame_sync();
        test_lz_blank();
        test_blink();
        test_reset_mid_and_load_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display path. It captures four BCD digits, cycles through them at a programmable refresh rate, and drives one shared BCD-to-seven-segment decoder. Its outputs are a single active-low segment bus and active-low digit enables. It also handles frame-synchronous updates, leading-zero blanking and per-digit blinking, and sits between the counter/stopwatch logic and the board display pins.

## Interface
- `CLK_DIV`, default 50000: clk cycles per scan tick; legal values are ≥ 2.
- `BLINK_FRAMES`, default 125: scan frames per blink half-period; legal values are ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d0`,`d1`,`d2`,`d3`  in  4 each  BCD digits; `d0` is least significant.
- `load`  in  1  one-cycle strobe that stages `d0`–`d3`.
- `blank_lz`  in  1  leading-zero blanking enable; level-sensitive.
- `blink_mask`  in  4  bit i set makes digit i blink.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}; registered.
- `an`  out  4  active-low digit enables, one-hot-low; registered.
- `frame_done`  out  1  one-cycle pulse at each frame start.

## Operation
- **Prescaler**
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` is asserted in the cycle where the count equals CLK_DIV-1.
  - Width is $clog2(CLK_DIV).
- **Digit index**
  - Resets to 3.
  - On `tick`, advances 3→0→1→2→3.
  - The advance 3→0 is a *wrap* and starts a new frame.
- **Staging**
  - `load` copies `d0`–`d3` into the staging register and sets `pending`.
  - A later `load` overwrites the staging register; last write wins.
- **Commit**
  - On a wrap with `pending` set, the staging register is copied to the display register and `pending` clears.
  - If `load` and a wrap fall in the same cycle, the `d` inputs of that cycle go straight to the display register and `pending` ends clear.
  - The display register never changes mid-frame, so there is no tearing.
- **Decode**
  - The value for the new index passes through the shared decoder.
  - Codes 0–9 use the standard active-low patterns, e.g. 0→1000000, 1→1111001, 8→0000000.
  - Codes 10–15 → 0000000 (all segments lit).
- **Blanking**: a blanked digit drives `seg`=1111111 and its `an` bit stays high (all enables off). Digit i is blanked when either:
  - `blank_lz`=1, i≥1, and display digits i..3 are all zero (digit 0 is never blanked); or
  - `blink_mask[i]`=1 and the blink phase is OFF.
- **Blink**
  - A frame counter increments on each wrap.
  - When it reaches BLINK_FRAMES it clears and the phase toggles.
  - Phase resets to ON (visible).

## Timing
- **Reset values**
  - `seg`=1111111, `an`=1111, `frame_done`=0.
  - Index=3, prescaler=0, display and staging registers=0, `pending`=0.
  - Blink phase ON, frame counter=0.
- **Reset mid-operation**: assertion returns every register to its reset value immediately; no partial frame completes.
- **Output latency**
  - `seg`/`an` for the new index are registered on the same edge that applies `tick`.
  - Each digit stays lit for exactly CLK_DIV cycles.
  - A full frame is 4·CLK_DIV cycles.
- **First frame**
  - The first tick after reset release occurs at the CLK_DIV-th rising edge.
  - That tick is a wrap: it lights digit 0, pulses `frame_done`, and commits any `pending` data.
- **Commit-to-display delay**: at most 4·CLK_DIV cycles from `load` to the first digit showing new data.
- **Blink period**: the phase toggles every BLINK_FRAMES·4·CLK_DIV cycles.
- **Input sampling**: `blank_lz` and `blink_mask` are sampled on each tick edge.

## Structure
- **Shared package `display_pkg`** holds:
  - active-low segment constants (SEG_BLANK=1111111, SEG_ERR=0000000);
  - AN_OFF=1111;
  - digit count NUM_DIGITS=4.
- **Decoder**: exactly one sub-module, the existing BCD-to-seven-segment decoder `BCD7`, instantiated once and fed by a 4:1 mux on the display register.
- **Remaining logic**: prescaler, index, staging/commit, blink and blanking stay in this module.

## Test plan
All scenarios use CLK_DIV=4 and BLINK_FRAMES=2.
- **Reset and first frame**: release reset with `load`=0. `an`=1111 until the edge at cycle 4; then `an`=1110, `seg`=1000000 (0), and `frame_done` pulses once.
- **Scan order**: `load` d3..d0=1,2,3,4. After the next wrap, `an` sequence is 1110,1101,1011,0111 with `seg` showing 4,3,2,1, each held 4 cycles.
- **Frame-synchronous update**: `load` 5678 mid-frame, then `load` 9999 one cycle later. The current frame is unchanged; the next frame shows 9,9,9,9; 5678 is never displayed.
- **Leading-zero blanking**: display 0,0,7,0 (d3..d0) with `blank_lz`=1.
  - Digits 3 and 2 are blanked (`an` bit high, `seg`=1111111); digits 1 and 0 show 7 and 0.
  - With `blank_lz`=0, all four digits light.
- **Blink and invalid code**: `blink_mask`=0001 with d0=12.
  - Digit 0 shows 0000000 for 2 frames, is blank for 2 frames, and repeats.
  - Digits 1–3 are unaffected.
- **Reset mid-frame and simultaneous load/wrap**
  - Assert `rst_n`=0 during digit 2: `an`=1111 in the same cycle.
  - `load` coinciding with a wrap tick: digit 0 shows the new value on that same edge and `pending` ends clear.
